// File: rtl/spot_finder_pkg.sv
// Shared definitions for the ROI spot detector: FSM encoding and ROI record layout.
package spot_finder_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        SCAN = 3'd3,
        DONE = 3'd4
    } state_e;

    // An ROI record is {x_start, y_start, x_end, y_end}, MSB to LSB.
    // Field indices below count from the LSB of the record.
    localparam int ROI_FIELDS = 4;
    localparam int ROI_F_YE   = 0;
    localparam int ROI_F_XE   = 1;
    localparam int ROI_F_YS   = 2;
    localparam int ROI_F_XS   = 3;

    function automatic int roi_rec_w(input int coord_w);
        return ROI_FIELDS * coord_w;
    endfunction

    function automatic int roi_field_lsb(input int field, input int coord_w);
        return field * coord_w;
    endfunction

endpackage

// File: rtl/roi_match_unit.sv
// Combinational hit test of one pixel against every live entry of the ROI table.
module roi_match_unit
    import spot_finder_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int MAX_ROIS = 10
) (
    input  logic [MAX_ROIS*ROI_FIELDS*COORD_W-1:0] roi_table,
    input  logic [7:0]                             num_rois,
    input  logic [COORD_W-1:0]                     pix_x,
    input  logic [COORD_W-1:0]                     pix_y,
    output logic                                   hit
);

    localparam int REC_W  = roi_rec_w(COORD_W);
    localparam int XS_LSB = roi_field_lsb(ROI_F_XS, COORD_W);
    localparam int YS_LSB = roi_field_lsb(ROI_F_YS, COORD_W);
    localparam int XE_LSB = roi_field_lsb(ROI_F_XE, COORD_W);
    localparam int YE_LSB = roi_field_lsb(ROI_F_YE, COORD_W);

    logic [MAX_ROIS-1:0] entry_hit_s;

    for (genvar k = 0; k < MAX_ROIS; k++) begin : g_entry
        logic [REC_W-1:0]   rec_s;
        logic [COORD_W-1:0] xs_s;
        logic [COORD_W-1:0] ys_s;
        logic [COORD_W-1:0] xe_s;
        logic [COORD_W-1:0] ye_s;

        assign rec_s = roi_table[k*REC_W +: REC_W];
        assign xs_s  = rec_s[XS_LSB +: COORD_W];
        assign ys_s  = rec_s[YS_LSB +: COORD_W];
        assign xe_s  = rec_s[XE_LSB +: COORD_W];
        assign ye_s  = rec_s[YE_LSB +: COORD_W];

        // Entries at or above num_rois are not yet filled and never match.
        assign entry_hit_s[k] = (8'(k) < num_rois) &&
                                (pix_x >= xs_s) && (pix_x <= xe_s) &&
                                (pix_y >= ys_s) && (pix_y <= ye_s);
    end

    // Any live entry covering the pixel suppresses a new ROI.
    always_comb begin
        hit = |entry_hit_s;
    end

endmodule

// File: rtl/roi_spot_detector.sv
// Frame scanner: reads image words, finds pixels above threshold and builds a table of ROIs around them.
module roi_spot_detector
    import spot_finder_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 32,
    parameter int ADDR_W       = 14,
    parameter int COORD_W      = 10,
    parameter int MAX_ROIS     = 10,
    parameter int ROI_W        = 7,
    parameter int ROI_H        = 7,
    parameter int RD_LATENCY   = 2
) (
    input  logic                            clk_in,
    input  logic                            reset,
    input  logic                            start,
    input  logic [PIX_W-1:0]                threshold,
    input  logic [15:0]                     cam_kernels_x,
    input  logic [15:0]                     cam_lines_y,
    output logic [ADDR_W-1:0]               mem_address,
    input  logic [PIX_W*PIX_PER_WORD-1:0]   data_in,
    output logic                            busy,
    output logic                            analysis_rdy,
    output logic                            overflow,
    output logic [7:0]                      num_rois,
    output logic [MAX_ROIS*4*COORD_W-1:0]   ROIs_output
);

    localparam int REC_W     = roi_rec_w(COORD_W);
    localparam int TBL_W     = MAX_ROIS * REC_W;
    localparam int PIX_IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [PIX_IDX_W-1:0] LAST_PIX    = PIX_IDX_W'(PIX_PER_WORD - 1);
    localparam logic [COORD_W-1:0]   HALF_X      = COORD_W'(ROI_W / 2);
    localparam logic [COORD_W-1:0]   HALF_Y      = COORD_W'(ROI_H / 2);
    localparam logic [2:0]           WAIT_LOAD   = 3'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);
    localparam logic [7:0]           TBL_FULL    = 8'(MAX_ROIS);

    state_e                 state_q,        state_d;
    logic [PIX_W-1:0]       thr_q,          thr_d;
    logic [15:0]            kx_q,           kx_d;
    logic [15:0]            ly_q,           ly_d;
    logic [COORD_W-1:0]     xmax_q,         xmax_d;
    logic [COORD_W-1:0]     ymax_q,         ymax_d;
    logic [15:0]            kidx_q,         kidx_d;
    logic [15:0]            lidx_q,         lidx_d;
    logic [PIX_IDX_W-1:0]   pix_q,          pix_d;
    logic [2:0]             wait_cnt_q,     wait_cnt_d;
    logic [ADDR_W-1:0]      mem_address_q,  mem_address_d;
    logic [7:0]             num_rois_q,     num_rois_d;
    logic [TBL_W-1:0]       rois_q,         rois_d;
    logic                   overflow_q,     overflow_d;
    logic                   rdy_q,          rdy_d;
    logic                   busy_q,         busy_d;

    logic [PIX_W-1:0]       cur_pix_s;
    logic [COORD_W-1:0]     pix_x_s;
    logic [COORD_W-1:0]     pix_y_s;
    logic                   bright_s;
    logic                   hit_s;
    logic [REC_W-1:0]       new_rec_s;

    // Select the pixel under examination from the current memory word.
    always_comb begin
        cur_pix_s = {PIX_W{1'b0}};
        for (int p = 0; p < PIX_PER_WORD; p++) begin
            if (pix_q == PIX_IDX_W'(p)) begin
                cur_pix_s = data_in[p*PIX_W +: PIX_W];
            end else begin
                cur_pix_s = cur_pix_s;
            end
        end
    end

    // Pixel coordinates, brightness and the candidate ROI clipped to the frame.
    always_comb begin
        pix_x_s   = COORD_W'(32'(kidx_q) * 32'(PIX_PER_WORD) + 32'(pix_q));
        pix_y_s   = COORD_W'(lidx_q);
        bright_s  = (cur_pix_s > thr_q);
        new_rec_s = {REC_W{1'b0}};
        new_rec_s[roi_field_lsb(ROI_F_XS, COORD_W) +: COORD_W] =
            (pix_x_s < HALF_X) ? {COORD_W{1'b0}} : (pix_x_s - HALF_X);
        new_rec_s[roi_field_lsb(ROI_F_YS, COORD_W) +: COORD_W] =
            (pix_y_s < HALF_Y) ? {COORD_W{1'b0}} : (pix_y_s - HALF_Y);
        // Widened compare so that coord+half never wraps before clipping.
        new_rec_s[roi_field_lsb(ROI_F_XE, COORD_W) +: COORD_W] =
            (({1'b0, pix_x_s} + {1'b0, HALF_X}) > {1'b0, xmax_q}) ? xmax_q : (pix_x_s + HALF_X);
        new_rec_s[roi_field_lsb(ROI_F_YE, COORD_W) +: COORD_W] =
            (({1'b0, pix_y_s} + {1'b0, HALF_Y}) > {1'b0, ymax_q}) ? ymax_q : (pix_y_s + HALF_Y);
    end

    roi_match_unit #(
        .COORD_W  (COORD_W),
        .MAX_ROIS (MAX_ROIS)
    ) u_match (
        .roi_table (rois_q),
        .num_rois  (num_rois_q),
        .pix_x     (pix_x_s),
        .pix_y     (pix_y_s),
        .hit       (hit_s)
    );

    // Next-state and next-register computation for the frame scan FSM.
    always_comb begin
        state_d       = state_q;
        thr_d         = thr_q;
        kx_d          = kx_q;
        ly_d          = ly_q;
        xmax_d        = xmax_q;
        ymax_d        = ymax_q;
        kidx_d        = kidx_q;
        lidx_d        = lidx_q;
        pix_d         = pix_q;
        wait_cnt_d    = wait_cnt_q;
        mem_address_d = mem_address_q;
        num_rois_d    = num_rois_q;
        rois_d        = rois_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    thr_d         = threshold;
                    kx_d          = cam_kernels_x;
                    ly_d          = cam_lines_y;
                    xmax_d        = COORD_W'(32'(cam_kernels_x) * 32'(PIX_PER_WORD) - 32'd1);
                    ymax_d        = COORD_W'(32'(cam_lines_y) - 32'd1);
                    kidx_d        = 16'd0;
                    lidx_d        = 16'd0;
                    pix_d         = {PIX_IDX_W{1'b0}};
                    wait_cnt_d    = 3'd0;
                    mem_address_d = {ADDR_W{1'b0}};
                    num_rois_d    = 8'd0;
                    rois_d        = {TBL_W{1'b0}};
                    overflow_d    = 1'b0;
                    if ((cam_kernels_x == 16'd0) || (cam_lines_y == 16'd0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                // ADDR plus WAIT cover the full memory read latency.
                if (RD_LATENCY <= 1) begin
                    state_d = SCAN;
                end else begin
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = SCAN;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            SCAN: begin
                if (bright_s && !hit_s && (num_rois_q == TBL_FULL)) begin
                    overflow_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    if (bright_s && !hit_s) begin
                        for (int k = 0; k < MAX_ROIS; k++) begin
                            if (num_rois_q == 8'(k)) begin
                                rois_d[k*REC_W +: REC_W] = new_rec_s;
                            end else begin
                                rois_d[k*REC_W +: REC_W] = rois_d[k*REC_W +: REC_W];
                            end
                        end
                        num_rois_d = num_rois_q + 8'd1;
                    end else begin
                        num_rois_d = num_rois_q;
                    end
                    if (pix_q == LAST_PIX) begin
                        pix_d         = {PIX_IDX_W{1'b0}};
                        mem_address_d = mem_address_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (kidx_q == (kx_q - 16'd1)) begin
                            kidx_d = 16'd0;
                            if (lidx_q == (ly_q - 16'd1)) begin
                                state_d = DONE;
                            end else begin
                                lidx_d  = lidx_q + 16'd1;
                                state_d = ADDR;
                            end
                        end else begin
                            kidx_d  = kidx_q + 16'd1;
                            state_d = ADDR;
                        end
                    end else begin
                        pix_d = pix_q + {{(PIX_IDX_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The done pulse follows the single DONE cycle.
        rdy_d  = (state_q == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q       <= IDLE;
            thr_q         <= {PIX_W{1'b0}};
            kx_q          <= 16'd0;
            ly_q          <= 16'd0;
            xmax_q        <= {COORD_W{1'b0}};
            ymax_q        <= {COORD_W{1'b0}};
            kidx_q        <= 16'd0;
            lidx_q        <= 16'd0;
            pix_q         <= {PIX_IDX_W{1'b0}};
            wait_cnt_q    <= 3'd0;
            mem_address_q <= {ADDR_W{1'b0}};
            num_rois_q    <= 8'd0;
            rois_q        <= {TBL_W{1'b0}};
            overflow_q    <= 1'b0;
            rdy_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            thr_q         <= thr_d;
            kx_q          <= kx_d;
            ly_q          <= ly_d;
            xmax_q        <= xmax_d;
            ymax_q        <= ymax_d;
            kidx_q        <= kidx_d;
            lidx_q        <= lidx_d;
            pix_q         <= pix_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_address_q <= mem_address_d;
            num_rois_q    <= num_rois_d;
            rois_q        <= rois_d;
            overflow_q    <= overflow_d;
            rdy_q         <= rdy_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_address  = mem_address_q;
    assign busy         = busy_q;
    assign analysis_rdy = rdy_q;
    assign overflow     = overflow_q;
    assign num_rois     = num_rois_q;
    assign ROIs_output  = rois_q;

endmodule

// File: tb/tb_roi_spot_detector.sv
// Self-checking bench for roi_spot_detector: vector table plus scoreboard, with reset and restart corner cases.
module tb_roi_spot_detector;

    localparam int ADDR_W   = 14;
    localparam int PPW      = 32;
    localparam int ROI_BITS = 400;
    localparam int LIMIT    = 2000;
    localparam int NVEC     = 11;

    logic                 clk_in = 1'b0;
    logic                 reset;
    logic                 start;
    logic [7:0]           threshold;
    logic [15:0]          cam_kernels_x;
    logic [15:0]          cam_lines_y;
    logic [ADDR_W-1:0]    mem_address;
    logic [255:0]         data_in;
    logic                 busy;
    logic                 analysis_rdy;
    logic                 overflow;
    logic [7:0]           num_rois;
    logic [ROI_BITS-1:0]  ROIs_output;

    typedef struct {
        logic [15:0]          kx;
        logic [15:0]          ly;
        logic [7:0]           thr;
        int                   npx;
        logic [10:0][6:0]     px_x;
        logic [10:0][2:0]     px_y;
        logic [10:0][7:0]     px_v;
        int                   exp_n;
        logic                 exp_ovf;
        int                   exp_lat;
        logic [ROI_BITS-1:0]  exp_roi;
    } vec_t;

    vec_t vecs [0:NVEC-1];
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Image memory model: word address a maps to line a/kx, kernel a%kx.
    logic [7:0]        img [0:7][0:95];
    int                mem_kx = 0;
    logic [ADDR_W-1:0] addr_d1;
    logic [255:0]      data_r;

    roi_spot_detector dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .start         (start),
        .threshold     (threshold),
        .cam_kernels_x (cam_kernels_x),
        .cam_lines_y   (cam_lines_y),
        .mem_address   (mem_address),
        .data_in       (data_in),
        .busy          (busy),
        .analysis_rdy  (analysis_rdy),
        .overflow      (overflow),
        .num_rois      (num_rois),
        .ROIs_output   (ROIs_output)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [255:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [255:0] w;
        int y;
        int k;
        int x;
        w = '0;
        if (mem_kx > 0) begin
            y = int'(a) / mem_kx;
            k = int'(a) % mem_kx;
            for (int p = 0; p < PPW; p++) begin
                x = k * PPW + p;
                if (y < 8 && x < 96) w[p*8 +: 8] = img[y][x];
            end
        end
        return w;
    endfunction

    // Two-cycle read latency: address registered, then data registered.
    always @(posedge clk_in) begin
        addr_d1 <= mem_address;
        data_r  <= mem_word(addr_d1);
    end
    assign data_in = data_r;

    function automatic vec_t dflt();
        vec_t v;
        v.kx = 16'd2; v.ly = 16'd4; v.thr = 8'd127; v.npx = 0;
        v.px_x = '0; v.px_y = '0; v.px_v = '0;
        v.exp_n = 0; v.exp_ovf = 1'b0; v.exp_lat = 273; v.exp_roi = '0;
        return v;
    endfunction

    function automatic vec_t with_px(input vec_t v, input int x, input int y, input int val);
        vec_t r;
        r = v;
        r.px_x[r.npx] = 7'(x);
        r.px_y[r.npx] = 3'(y);
        r.px_v[r.npx] = 8'(val);
        r.npx++;
        return r;
    endfunction

    function automatic logic [39:0] roi(input int xs, input int ys, input int xe, input int ye);
        return {10'(xs), 10'(ys), 10'(xe), 10'(ye)};
    endfunction

    task automatic chk(input string what, input logic [ROI_BITS-1:0] act, input logic [ROI_BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic load_image(input vec_t v);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 96; x++)
                img[y][x] = 8'd0;
        for (int i = 0; i < v.npx; i++)
            img[v.px_y[i]][v.px_x[i]] = v.px_v[i];
        mem_kx = int'(v.kx);
    endtask

    // Runs one frame; restart_at >= 0 pulses a bogus start that many cycles in.
    task automatic run_vec(input int i, input int restart_at);
        vec_t v;
        vec_t e;
        int   lat;
        v = vecs[i];
        load_image(v);
        @(negedge clk_in);
        threshold = v.thr; cam_kernels_x = v.kx; cam_lines_y = v.ly; start = 1'b1;
        sb_q.push_back(v);
        @(negedge clk_in);
        start = 1'b0;
        chk($sformatf("v%0d_busy", i), ROI_BITS'(busy), ROI_BITS'(1));
        lat = 0;
        while (analysis_rdy !== 1'b1 && lat < LIMIT) begin
            if (lat == restart_at) begin
                start = 1'b1; threshold = 8'd0; cam_kernels_x = 16'd3; cam_lines_y = 16'd1;
            end else begin
                start = 1'b0; threshold = v.thr; cam_kernels_x = v.kx; cam_lines_y = v.ly;
            end
            @(negedge clk_in);
            lat++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        chk($sformatf("v%0d_latency", i), ROI_BITS'(lat), ROI_BITS'(e.exp_lat));
        chk($sformatf("v%0d_num_rois", i), ROI_BITS'(num_rois), ROI_BITS'(e.exp_n));
        chk($sformatf("v%0d_overflow", i), ROI_BITS'(overflow), ROI_BITS'(e.exp_ovf));
        chk($sformatf("v%0d_rois", i), ROIs_output, e.exp_roi);
        @(negedge clk_in);
        chk($sformatf("v%0d_rdy_pulse", i), ROI_BITS'(analysis_rdy), ROI_BITS'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, ROI_BITS'(busy), ROI_BITS'(0));
        chk({tag, "_rdy"}, ROI_BITS'(analysis_rdy), ROI_BITS'(0));
        chk({tag, "_ovf"}, ROI_BITS'(overflow), ROI_BITS'(0));
        chk({tag, "_num"}, ROI_BITS'(num_rois), ROI_BITS'(0));
        chk({tag, "_addr"}, ROI_BITS'(mem_address), ROI_BITS'(0));
        chk({tag, "_rois"}, ROIs_output, ROI_BITS'(0));
    endtask

    // Reset asserted during the SCAN of word 3 must abort the frame immediately.
    task automatic reset_mid_scan();
        int lat;
        load_image(vecs[3]);
        @(negedge clk_in);
        threshold = 8'd127; cam_kernels_x = 16'd2; cam_lines_y = 16'd4; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        lat = 0;
        while (lat < 110) begin
            @(negedge clk_in);
            lat++;
        end
        chk("mid_addr", ROI_BITS'(mem_address), ROI_BITS'(3));
        chk("mid_busy", ROI_BITS'(busy), ROI_BITS'(1));
        chk("mid_num", ROI_BITS'(num_rois), ROI_BITS'(1));
        reset = 1'b0;
        @(negedge clk_in);
        check_all_zero("abort");
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("abort_idle", ROI_BITS'(busy), ROI_BITS'(0));
    endtask

    initial begin
        vecs[0] = dflt();

        vecs[1] = with_px(dflt(), 40, 2, 200);
        vecs[1].exp_n = 1;
        vecs[1].exp_roi[39:0] = roi(37, 0, 43, 3);

        vecs[2] = with_px(dflt(), 40, 2, 127);

        vecs[3] = with_px(with_px(dflt(), 0, 0, 200), 63, 3, 200);
        vecs[3].exp_n = 2;
        vecs[3].exp_roi[39:0]  = roi(0, 0, 3, 3);
        vecs[3].exp_roi[79:40] = roi(60, 0, 63, 3);

        // Line 1 is scanned first, so (43,1) seeds the ROI that absorbs the others.
        vecs[4] = with_px(with_px(with_px(dflt(), 40, 2, 200), 41, 2, 200), 43, 1, 200);
        vecs[4].exp_n = 1;
        vecs[4].exp_roi[39:0] = roi(40, 0, 46, 3);

        // (41,2) lands inside the ROI made one cycle earlier; (44,2) falls outside it.
        vecs[5] = with_px(with_px(with_px(dflt(), 40, 2, 200), 41, 2, 200), 44, 2, 200);
        vecs[5].exp_n = 2;
        vecs[5].exp_roi[39:0]  = roi(37, 0, 43, 3);
        vecs[5].exp_roi[79:40] = roi(41, 0, 47, 3);

        vecs[6] = dflt();
        vecs[6].kx = 16'd3;
        for (int i = 0; i < 11; i++) vecs[6] = with_px(vecs[6], 8 * i, 0, 200);
        for (int i = 0; i < 10; i++)
            vecs[6].exp_roi[40*i +: 40] = roi((8 * i < 3) ? 0 : 8 * i - 3, 0, 8 * i + 3, 3);
        vecs[6].exp_n = 10; vecs[6].exp_ovf = 1'b1; vecs[6].exp_lat = 88;

        vecs[7] = with_px(dflt(), 40, 2, 200);
        vecs[7].kx = 16'd0; vecs[7].exp_lat = 1;

        vecs[8] = with_px(with_px(dflt(), 5, 3, 201), 60, 0, 200);
        vecs[8].thr = 8'd200; vecs[8].exp_n = 1;
        vecs[8].exp_roi[39:0] = roi(2, 0, 8, 3);

        vecs[9] = with_px(dflt(), 20, 5, 255);
        vecs[9].ly = 16'd8; vecs[9].exp_n = 1; vecs[9].exp_lat = 545;
        vecs[9].exp_roi[39:0] = roi(17, 2, 23, 7);

        vecs[10] = dflt();
        vecs[10].ly = 16'd0; vecs[10].exp_lat = 1;

        // Reset with start held high: start must be ignored.
        reset = 1'b0; start = 1'b1; threshold = 8'd127;
        cam_kernels_x = 16'd2; cam_lines_y = 16'd4;
        load_image(vecs[0]);
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        reset = 1'b1; start = 1'b0;
        @(negedge clk_in);
        chk("post_reset_idle", ROI_BITS'(busy), ROI_BITS'(0));

        for (int i = 0; i < NVEC; i++) run_vec(i, -1);

        // Start pulses while busy are ignored; the frame finishes as if undisturbed.
        run_vec(1, 50);
        run_vec(3, 271);

        reset_mid_scan();
        run_vec(5, -1);

        chk("sb_empty", ROI_BITS'(sb_q.size()), ROI_BITS'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
